ltl_report_collector: RTL and testbench

- Downstream consumer of one LTL monitor automaton's report outputs, e.g. the four report lines of a monitor cluster.
- On every symbol cycle in which any report line is active, it captures a record: symbol index plus report vector.
- Records are buffered in a small FIFO and drained to the monitor readout/CSR path over a valid/ready interface.
- Also tracks sticky per-report hit flags and FIFO overflow.

---
 rtl/ltl_report_collector.sv | 164 ++++++++++++++++
 tb/tb_ltl_report_collector.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ltl_report_collector.sv
// Report collector for one LTL monitor automaton: captures {symbol index, report vector}
// records into a FIFO and tracks sticky hit flags and overflow.
// Latency: a record pushed in cycle N is visible on rec_*_o in cycle N+1 when the FIFO was empty.
// Backpressure: rec_valid_o/rec_ready_i handshake. A push into a full FIFO with no pop is dropped and sets overflow_o.
// Optional feature macro: LTL_REPORT_COALESCE_EN merges consecutive identical reports into the tail
// record and adds the rec_cnt_o repeat-count port.
module ltl_report_collector #(
  parameter int NUM_REPORTS = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int IDX_WIDTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          run,
  input  logic                          clear,
  input  logic [NUM_REPORTS-1:0]        report_i,
  output logic                          rec_valid_o,
  input  logic                          rec_ready_i,
  output logic [IDX_WIDTH-1:0]          rec_idx_o,
  output logic [NUM_REPORTS-1:0]        rec_vec_o,
`ifdef LTL_REPORT_COALESCE_EN
  output logic [IDX_WIDTH-1:0]          rec_cnt_o,
`endif
  output logic [NUM_REPORTS-1:0]        hit_sticky_o,
  output logic                          overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  // Record storage. Entries are only observed while valid, so their contents need no clear.
  logic [IDX_WIDTH-1:0]   idx_mem_q [FIFO_DEPTH];
  logic [NUM_REPORTS-1:0] vec_mem_q [FIFO_DEPTH];
`ifdef LTL_REPORT_COALESCE_EN
  logic [IDX_WIDTH-1:0]   cnt_mem_q [FIFO_DEPTH];
`endif

  // Pointers carry a wrap bit above the address so full and empty can be told apart.
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [IDX_WIDTH-1:0]   sym_cnt_q, sym_cnt_d;
  logic [NUM_REPORTS-1:0] hit_q, hit_d;
  logic                   ovf_q, ovf_d;

  logic [AW-1:0]          wr_addr;
  logic [AW-1:0]          rd_addr;
  logic [PW-1:0]          level;
  logic                   empty;
  logic                   full;
  logic                   push_req;
  logic                   pop;
  logic                   merge;
  logic                   alloc;
  logic                   drop;

  assign wr_addr = wr_ptr_q[AW-1:0];
  assign rd_addr = rd_ptr_q[AW-1:0];
  assign level   = wr_ptr_q - rd_ptr_q;
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_addr == rd_addr);

  // clear discards any push or pop presented in the same cycle.
  assign push_req = run && (|report_i) && !clear;
  assign pop      = rec_valid_o && rec_ready_i && !clear;

`ifdef LTL_REPORT_COALESCE_EN
  logic [AW-1:0]        tail_addr;
  logic [IDX_WIDTH-1:0] tail_next_idx;
  logic                 tail_popped;

  assign tail_addr     = wr_addr - AW'(1);
  // A tail record covers symbols idx..idx+cnt, so the next consecutive symbol is idx+cnt+1.
  assign tail_next_idx = idx_mem_q[tail_addr] + cnt_mem_q[tail_addr] + IDX_WIDTH'(1);
  assign tail_popped   = pop && (level == PW'(1));
  assign merge = push_req && !empty && !tail_popped
              && (report_i == vec_mem_q[tail_addr])
              && (sym_cnt_q == tail_next_idx)
              && (cnt_mem_q[tail_addr] != {IDX_WIDTH{1'b1}});
`else
  assign merge = 1'b0;
`endif

  // A full FIFO still takes a new entry when the head leaves in the same cycle.
  assign alloc = push_req && !merge && (!full || pop);
  assign drop  = push_req && !merge && full && !pop;

  // Next-state for pointers, symbol counter and sticky flags; clear wins over everything.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    sym_cnt_d = sym_cnt_q;
    hit_d     = hit_q;
    ovf_d     = ovf_q;
    if (clear) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      sym_cnt_d = '0;
      hit_d     = '0;
      ovf_d     = 1'b0;
    end else begin
      if (alloc) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
      if (run) begin
        sym_cnt_d = sym_cnt_q + IDX_WIDTH'(1);
        hit_d     = hit_q | report_i;
      end
      if (drop) ovf_d = 1'b1;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      sym_cnt_q <= '0;
      hit_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      sym_cnt_q <= sym_cnt_d;
      hit_q     <= hit_d;
      ovf_q     <= ovf_d;
    end
  end

  // Record storage writes: new entries at the write pointer, merges bump the tail count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        idx_mem_q[i] <= '0;
        vec_mem_q[i] <= '0;
`ifdef LTL_REPORT_COALESCE_EN
        cnt_mem_q[i] <= '0;
`endif
      end
    end else begin
      if (alloc) begin
        idx_mem_q[wr_addr] <= sym_cnt_q;
        vec_mem_q[wr_addr] <= report_i;
`ifdef LTL_REPORT_COALESCE_EN
        cnt_mem_q[wr_addr] <= '0;
`endif
      end
`ifdef LTL_REPORT_COALESCE_EN
      if (merge) cnt_mem_q[tail_addr] <= cnt_mem_q[tail_addr] + IDX_WIDTH'(1);
`endif
    end
  end

  // Head is read straight from storage; outputs are zeroed while empty.
  assign rec_valid_o  = !empty;
  assign rec_idx_o    = rec_valid_o ? idx_mem_q[rd_addr] : '0;
  assign rec_vec_o    = rec_valid_o ? vec_mem_q[rd_addr] : '0;
`ifdef LTL_REPORT_COALESCE_EN
  assign rec_cnt_o    = rec_valid_o ? cnt_mem_q[rd_addr] : '0;
`endif
  assign hit_sticky_o = hit_q;
  assign overflow_o   = ovf_q;
  assign level_o      = level;

endmodule

// File: tb/tb_ltl_report_collector.sv
// Directed bench for ltl_report_collector: default instance plus an IDX_WIDTH=4 instance for wrap.
module tb_ltl_report_collector;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0, clear = 1'b0, ready = 1'b0;
  logic [3:0] rep = 4'd0;
  logic       valid, ovf;
  logic [15:0] idx;
  logic [3:0] vec, sticky, level;
`ifdef LTL_REPORT_COALESCE_EN
  logic [15:0] cnt;
`endif

  logic       run4 = 1'b0, clear4 = 1'b0, ready4 = 1'b0;
  logic [3:0] rep4 = 4'd0;
  logic       valid4, ovf4;
  logic [3:0] idx4, vec4, sticky4, level4;
`ifdef LTL_REPORT_COALESCE_EN
  logic [3:0] cnt4;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  ltl_report_collector dut (
    .clk(clk), .rst_n(rst_n), .run(run), .clear(clear), .report_i(rep),
    .rec_valid_o(valid), .rec_ready_i(ready), .rec_idx_o(idx), .rec_vec_o(vec),
`ifdef LTL_REPORT_COALESCE_EN
    .rec_cnt_o(cnt),
`endif
    .hit_sticky_o(sticky), .overflow_o(ovf), .level_o(level)
  );

  ltl_report_collector #(.IDX_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .run(run4), .clear(clear4), .report_i(rep4),
    .rec_valid_o(valid4), .rec_ready_i(ready4), .rec_idx_o(idx4), .rec_vec_o(vec4),
`ifdef LTL_REPORT_COALESCE_EN
    .rec_cnt_o(cnt4),
`endif
    .hit_sticky_o(sticky4), .overflow_o(ovf4), .level_o(level4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    tests_run++;
    if ({valid, idx, vec, sticky, ovf, level} !== 30'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs got v=%b idx=%0d vec=%b st=%b ov=%b lvl=%0d exp all zero",
               valid, idx, vec, sticky, ovf, level);
    end
    #10 rst_n = 1'b1;
    step();
    // report lines ignored without run
    rep = 4'b1111;
    step();
    tests_run++;
    if (valid !== 1'b0 || sticky !== 4'b0000) begin
      tests_failed++;
      $display("FAIL no_run_ignored got v=%b st=%b exp v=0 st=0000", valid, sticky);
    end
  endtask

  task automatic test_first_record();
    run = 1'b1; rep = 4'b0000;
    repeat (5) step();
    rep = 4'b0100;
    tests_run++;
    if (valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL no_comb_path got v=%b exp 0", valid);
    end
    step();
    run = 1'b0; rep = 4'b0000;
    tests_run++;
    if (valid !== 1'b1 || idx !== 16'd5 || vec !== 4'b0100 || sticky !== 4'b0100 || level !== 4'd1) begin
      tests_failed++;
      $display("FAIL first_record got v=%b idx=%0d vec=%b st=%b lvl=%0d exp v=1 idx=5 vec=0100 st=0100 lvl=1",
               valid, idx, vec, sticky, level);
    end
    ready = 1'b1; step(); ready = 1'b0;
    tests_run++;
    if (valid !== 1'b0 || level !== 4'd0) begin
      tests_failed++;
      $display("FAIL first_pop got v=%b lvl=%0d exp v=0 lvl=0", valid, level);
    end
  endtask

  task automatic test_overflow();
    do_clear();
    run = 1'b1; rep = 4'b0001;
    repeat (8) step();
    tests_run++;
    if (level !== 4'd8 || ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL fill8 got lvl=%0d ov=%b exp lvl=8 ov=0", level, ovf);
    end
    step();
    run = 1'b0; rep = 4'b0000;
    tests_run++;
    if (level !== 4'd8 || ovf !== 1'b1 || sticky !== 4'b0001) begin
      tests_failed++;
      $display("FAIL overflow got lvl=%0d ov=%b st=%b exp lvl=8 ov=1 st=0001", level, ovf, sticky);
    end
    step();
    tests_run++;
    if (idx !== 16'd0 || vec !== 4'b0001 || valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL hold_stable got v=%b idx=%0d vec=%b exp v=1 idx=0 vec=0001", valid, idx, vec);
    end
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (valid !== 1'b1 || idx !== 16'(i) || vec !== 4'b0001) begin
        tests_failed++;
        $display("FAIL drain_ovf[%0d] got v=%b idx=%0d vec=%b exp v=1 idx=%0d vec=0001", i, valid, idx, vec, i);
      end
      ready = 1'b1; step(); ready = 1'b0;
    end
    tests_run++;
    if (valid !== 1'b0 || level !== 4'd0 || ovf !== 1'b1) begin
      tests_failed++;
      $display("FAIL drained_ovf got v=%b lvl=%0d ov=%b exp v=0 lvl=0 ov=1", valid, level, ovf);
    end
  endtask

  task automatic test_clear();
    run = 1'b1;
    rep = 4'b1000; step();
    rep = 4'b0100; step();
    rep = 4'b0010; step();
    tests_run++;
    if (level !== 4'd3) begin
      tests_failed++;
      $display("FAIL pre_clear_level got %0d exp 3", level);
    end
    clear = 1'b1; rep = 4'b0100; ready = 1'b1;
    step();
    clear = 1'b0; run = 1'b0; rep = 4'b0000; ready = 1'b0;
    tests_run++;
    if (level !== 4'd0 || valid !== 1'b0 || ovf !== 1'b0 || sticky !== 4'b0000) begin
      tests_failed++;
      $display("FAIL clear got lvl=%0d v=%b ov=%b st=%b exp lvl=0 v=0 ov=0 st=0000", level, valid, ovf, sticky);
    end
    run = 1'b1; rep = 4'b0001; step();
    run = 1'b0; rep = 4'b0000;
    tests_run++;
    if (valid !== 1'b1 || idx !== 16'd0 || sticky !== 4'b0001) begin
      tests_failed++;
      $display("FAIL post_clear_idx got v=%b idx=%0d st=%b exp v=1 idx=0 st=0001", valid, idx, sticky);
    end
    ready = 1'b1; step(); ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    do_clear();
    run = 1'b1; rep = 4'b0010;
    repeat (8) step();
    ready = 1'b1;
    step();
    run = 1'b0; rep = 4'b0000; ready = 1'b0;
    tests_run++;
    if (level !== 4'd8 || ovf !== 1'b0 || idx !== 16'd1) begin
      tests_failed++;
      $display("FAIL full_push_pop got lvl=%0d ov=%b idx=%0d exp lvl=8 ov=0 idx=1", level, ovf, idx);
    end
    for (int i = 1; i <= 8; i++) begin
      tests_run++;
      if (valid !== 1'b1 || idx !== 16'(i)) begin
        tests_failed++;
        $display("FAIL drain_full[%0d] got v=%b idx=%0d exp v=1 idx=%0d", i, valid, idx, i);
      end
      ready = 1'b1; step(); ready = 1'b0;
    end
  endtask

  task automatic test_wrap();
    run4 = 1'b1;
    for (int i = 0; i < 17; i++) begin
      rep4 = (i == 15) ? 4'b0011 : (i == 16) ? 4'b0101 : 4'b0000;
      step();
    end
    run4 = 1'b0; rep4 = 4'b0000;
    tests_run++;
    if (level4 !== 4'd2 || idx4 !== 4'd15 || vec4 !== 4'b0011) begin
      tests_failed++;
      $display("FAIL wrap_first got lvl=%0d idx=%0d vec=%b exp lvl=2 idx=15 vec=0011", level4, idx4, vec4);
    end
    ready4 = 1'b1; step(); ready4 = 1'b0;
    tests_run++;
    if (valid4 !== 1'b1 || idx4 !== 4'd0 || vec4 !== 4'b0101 || sticky4 !== 4'b0111) begin
      tests_failed++;
      $display("FAIL wrap_second got v=%b idx=%0d vec=%b st=%b exp v=1 idx=0 vec=0101 st=0111",
               valid4, idx4, vec4, sticky4);
    end
    ready4 = 1'b1; step(); ready4 = 1'b0;
  endtask

`ifdef LTL_REPORT_COALESCE_EN
  task automatic test_coalesce();
    do_clear();
    run = 1'b1; rep = 4'b0000;
    repeat (2) step();
    rep = 4'b1000;
    repeat (4) step();
    run = 1'b0; rep = 4'b0000;
    tests_run++;
    if (level !== 4'd1 || idx !== 16'd2 || vec !== 4'b1000 || cnt !== 16'd3) begin
      tests_failed++;
      $display("FAIL coalesce got lvl=%0d idx=%0d vec=%b cnt=%0d exp lvl=1 idx=2 vec=1000 cnt=3",
               level, idx, vec, cnt);
    end
    ready = 1'b1; step(); ready = 1'b0;
  endtask
`endif

  task automatic test_async_reset();
    do_clear();
    run = 1'b1; rep = 4'b0110; step();
    run = 1'b0; rep = 4'b0000;
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (valid !== 1'b0 || level !== 4'd0 || sticky !== 4'b0000) begin
      tests_failed++;
      $display("FAIL async_reset got v=%b lvl=%0d st=%b exp v=0 lvl=0 st=0000", valid, level, sticky);
    end
    #2 rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_first_record();
`ifndef LTL_REPORT_COALESCE_EN
    test_overflow();
`endif
    test_clear();
`ifndef LTL_REPORT_COALESCE_EN
    test_full_push_pop();
`endif
    test_wrap();
`ifdef LTL_REPORT_COALESCE_EN
    test_coalesce();
`endif
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
